keypad_event_debouncer: RTL and testbench

Parametrised next-generation keypad debouncer between the keypad scanner and the key decoder. Accepts any ROWS x COLS matrix, debounces both press and release, and emits single-cycle press, release and (optionally) auto-repeat event pulses alongside the level-style key_valid/key_row/key_col outputs. All outputs are registered.

---
 rtl/keypad_event_debouncer_if.sv | 32 +++
 rtl/keypad_event_debouncer.sv | 171 +++++++++++++++++
 tb/tb_keypad_event_debouncer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_event_debouncer_if.sv
// keypad_event_debouncer_if
//   Bundles the scanner-side inputs and the debounced key outputs of
//   keypad_event_debouncer.
//   Scanner -> debouncer : key_detected, row_idx (one-hot), col_sync (active-low)
//   Debouncer -> decoder : key_valid, key_row, key_col, key_press,
//                          key_release, key_repeat
//   master : scanner/decoder side (drives the inputs, observes the outputs)
//   slave  : the debouncer itself
interface keypad_event_debouncer_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   logic            key_detected;
   logic [ROWS-1:0] row_idx;
   logic [COLS-1:0] col_sync;
   logic            key_valid;
   logic [ROWS-1:0] key_row;
   logic [COLS-1:0] key_col;
   logic            key_press;
   logic            key_release;
   logic            key_repeat;

   modport master (
      output key_detected, row_idx, col_sync,
      input  key_valid, key_row, key_col, key_press, key_release, key_repeat
   );

   modport slave (
      input  key_detected, row_idx, col_sync,
      output key_valid, key_row, key_col, key_press, key_release, key_repeat
   );
endinterface

// File: rtl/keypad_event_debouncer.sv
// keypad_event_debouncer
//   Debounces press and release of a single key on a ROWS x COLS matrix and
//   emits one-cycle press / release / auto-repeat pulses next to the level
//   outputs key_valid / key_row / key_col. All outputs are registered.
//   Ports:
//     clk  - single clock
//     rst  - synchronous reset, active-high
//     kp   - keypad_event_debouncer_if.slave (scanner inputs, key outputs)
//   Build option:
//     KEYPAD_AUTOREPEAT_EN - when defined, the auto-repeat counter is built;
//                            otherwise key_repeat is tied low and
//                            REPEAT_DELAY / REPEAT_RATE have no effect.
module keypad_event_debouncer #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int DEBOUNCE_CYCLES = 60000,
   parameter int RELEASE_CYCLES  = 15000,
   parameter int REPEAT_DELAY    = 1500000,
   parameter int REPEAT_RATE     = 300000
) (
   input logic                     clk,
   input logic                     rst,
   keypad_event_debouncer_if.slave kp
);

   if (DEBOUNCE_CYCLES < 1 || RELEASE_CYCLES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_event_debouncer: all cycle parameters must be >= 1");
   end

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_PRESS_DB   = 2'd1;
   localparam logic [1:0] S_HELD       = 2'd2;
   localparam logic [1:0] S_RELEASE_DB = 2'd3;

   logic [1:0]      state;
   logic [CNT_W-1:0] cnt;
   logic [ROWS-1:0] lat_row;
   logic [COLS-1:0] lat_col;

   logic [COLS-1:0] cand_col;
   logic            cand;
   logic            match;

   // Exactly one row and exactly one pressed column; ghosting or multi-key
   // patterns are never treated as a key.
   always_comb begin
      cand_col = ~kp.col_sync;
      cand     = kp.key_detected && $onehot(kp.row_idx) && $onehot(cand_col);
      match    = cand && (kp.row_idx == lat_row) && (cand_col == lat_col);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         lat_row        <= '0;
         lat_col        <= '0;
         kp.key_valid   <= 1'b0;
         kp.key_row     <= '0;
         kp.key_col     <= '0;
         kp.key_press   <= 1'b0;
         kp.key_release <= 1'b0;
      end else begin
         kp.key_press   <= 1'b0;
         kp.key_release <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cand) begin
                  lat_row <= kp.row_idx;
                  lat_col <= cand_col;
                  cnt     <= '0;
                  state   <= S_PRESS_DB;
               end
            end
            S_PRESS_DB: begin
               if (!cand) begin
                  state <= S_IDLE;
               end else if (!match) begin
                  lat_row <= kp.row_idx;
                  lat_col <= cand_col;
                  cnt     <= '0;
               end else if (cnt == DEB_LAST) begin
                  state        <= S_HELD;
                  kp.key_valid <= 1'b1;
                  kp.key_row   <= lat_row;
                  kp.key_col   <= lat_col;
                  kp.key_press <= 1'b1;
               end else begin
                  cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
               end
            end
            // HELD and RELEASE_DB share the match / key-change handling; they
            // differ only in what an absent candidate does.
            default: begin
               if (match) begin
                  state <= S_HELD;
               end else if (cand) begin
                  kp.key_release <= 1'b1;
                  kp.key_valid   <= 1'b0;
                  kp.key_row     <= '0;
                  kp.key_col     <= '0;
                  lat_row        <= kp.row_idx;
                  lat_col        <= cand_col;
                  cnt            <= '0;
                  state          <= S_PRESS_DB;
               end else if (state == S_HELD) begin
                  cnt   <= '0;
                  state <= S_RELEASE_DB;
               end else if (cnt == REL_LAST) begin
                  kp.key_release <= 1'b1;
                  kp.key_valid   <= 1'b0;
                  kp.key_row     <= '0;
                  kp.key_col     <= '0;
                  state          <= S_IDLE;
               end else begin
                  cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_phase;   // 0: waiting for first repeat, 1: steady rate
   logic             held_entry;
   logic             rpt_advance;
   logic             rpt_hit;

   // The repeat counter only advances on cycles where the key is actually
   // held; release-debounce cycles and the bounce-return edge leave it frozen.
   always_comb begin
      held_entry  = (state == S_PRESS_DB) && match && (cnt == DEB_LAST);
      rpt_advance = (state == S_HELD) && match;
      rpt_hit     = rpt_advance && (rpt_cnt == (rpt_phase ? RATE_LAST : DELAY_LAST));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_cnt       <= '0;
         rpt_phase     <= 1'b0;
         kp.key_repeat <= 1'b0;
      end else begin
         kp.key_repeat <= rpt_hit;
         if (held_entry) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
         end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b1;
         end else if (rpt_advance && rpt_cnt != '1) begin
            rpt_cnt <= rpt_cnt + 1'b1;
         end
      end
   end
`else
   assign kp.key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_event_debouncer.sv
// tb_keypad_event_debouncer
//   Directed scenarios followed by randomized key patterns, every cycle
//   compared against a behavioural model based on run lengths of identical
//   candidate samples.
module tb_keypad_event_debouncer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DEB  = 8;
   localparam int REL  = 4;
   localparam int DLY  = 20;
   localparam int RATE = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   localparam bit AUTOREPEAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_event_debouncer_if #(.ROWS(ROWS), .COLS(COLS)) kp_if ();

   keypad_event_debouncer #(
      .ROWS(ROWS), .COLS(COLS),
      .DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp(kp_if)
   );

   int nchk  = 0;
   int nfail = 0;

   // Model state: key code = row*COLS+col, -1 for none.
   int m_key  = -1;
   int m_run  = 0;    // consecutive identical candidate samples while not held
   int m_gap  = 0;    // consecutive absent samples while held
   int m_n    = 0;    // held-and-matching edges since the press
   bit m_held = 0;
   bit e_press, e_rel, e_rpt;

   function automatic int cand_code(input logic det, input logic [ROWS-1:0] row,
                                    input logic [COLS-1:0] cs);
      int nr = 0, nc = 0, r = 0, c = 0;
      logic [COLS-1:0] pc;
      pc = ~cs;
      for (int i = 0; i < ROWS; i++) if (row[i] === 1'b1) begin nr++; r = i; end
      for (int i = 0; i < COLS; i++) if (pc[i] === 1'b1) begin nc++; c = i; end
      return (det === 1'b1 && nr == 1 && nc == 1) ? r * COLS + c : -1;
   endfunction

   task automatic model_step(input bit r, input int c);
      e_press = 0; e_rel = 0; e_rpt = 0;
      if (r) begin
         m_held = 0; m_key = -1; m_run = 0; m_gap = 0; m_n = 0;
      end else if (!m_held) begin
         if (c < 0) begin
            m_key = -1; m_run = 0;
         end else begin
            if (c == m_key) m_run++;
            else begin m_key = c; m_run = 1; end
            if (m_run == DEB + 1) begin
               m_held = 1; e_press = 1; m_n = 0; m_gap = 0;
            end
         end
      end else begin
         if (c == m_key) begin
            if (m_gap > 0) m_gap = 0;
            else begin
               m_n++;
               if (AUTOREPEAT && (m_n == DLY || (m_n > DLY && (m_n - DLY) % RATE == 0)))
                  e_rpt = 1;
            end
         end else if (c < 0) begin
            m_gap++;
            if (m_gap == REL + 1) begin
               e_rel = 1; m_held = 0; m_key = -1; m_run = 0;
            end
         end else begin
            e_rel = 1; m_held = 0; m_key = c; m_run = 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit r, input logic det, input logic [ROWS-1:0] row,
                       input logic [COLS-1:0] cs);
      int c;
      logic [31:0] erow, ecol;
      @(negedge clk);
      rst                = r;
      kp_if.key_detected = det;
      kp_if.row_idx      = row;
      kp_if.col_sync     = cs;
      @(posedge clk);
      c = cand_code(det, row, cs);
      model_step(r, c);
      erow = m_held ? (32'd1 << (m_key / COLS)) : 32'd0;
      ecol = m_held ? (32'd1 << (m_key % COLS)) : 32'd0;
      #1;
      check("key_valid",   32'(kp_if.key_valid),   32'(m_held));
      check("key_row",     32'(kp_if.key_row),     erow);
      check("key_col",     32'(kp_if.key_col),     ecol);
      check("key_press",   32'(kp_if.key_press),   32'(e_press));
      check("key_release", 32'(kp_if.key_release), 32'(e_rel));
      check("key_repeat",  32'(kp_if.key_repeat),  32'(e_rpt));
   endtask

   task automatic hold(input int n, input bit r, input logic det,
                       input logic [ROWS-1:0] row, input logic [COLS-1:0] cs);
      for (int i = 0; i < n; i++) step(r, det, row, cs);
   endtask

   initial begin
      logic [ROWS-1:0] rw;
      logic [COLS-1:0] cs;
      logic            det;
      int              sel, len;

      kp_if.key_detected = 1'b0;
      kp_if.row_idx      = '0;
      kp_if.col_sync     = '1;

      // Reset state
      hold(2, 1, 1'b0, 4'b0000, 4'b1111);
      // Clean press, then hold long enough for several repeats
      hold(50, 0, 1'b1, 4'b0010, 4'b1011);
      // Release bounce of 2 cycles, then a full release
      hold(2, 0, 1'b0, 4'b0010, 4'b1011);
      hold(6, 0, 1'b1, 4'b0010, 4'b1011);
      hold(8, 0, 1'b0, 4'b0000, 4'b1111);
      // Press bounce: drops at the 6th sample, then returns
      hold(5, 0, 1'b1, 4'b0100, 4'b0111);
      hold(1, 0, 1'b0, 4'b0100, 4'b0111);
      hold(12, 0, 1'b1, 4'b0100, 4'b0111);
      // Key change while held
      hold(12, 0, 1'b1, 4'b0100, 4'b1110);
      // Reset while held: no release pulse
      hold(1, 1, 1'b1, 4'b0100, 4'b1110);
      hold(3, 0, 1'b0, 4'b0000, 4'b1111);
      // Invalid inputs: two columns, two rows
      hold(12, 0, 1'b1, 4'b0010, 4'b1010);
      hold(12, 0, 1'b1, 4'b0011, 4'b1011);
      hold(4, 0, 1'b0, 4'b0000, 4'b1111);

      // Randomized segments
      rw = 4'b0001; cs = 4'b1110; det = 1'b1;
      for (int seg = 0; seg < 250; seg++) begin
         sel = int'($urandom_range(0, 9));
         len = int'($urandom_range(1, 30));
         if (sel <= 3) begin
            rw  = 4'b0001 << $urandom_range(0, 1);
            cs  = ~(4'b0001 << $urandom_range(0, 1));
            det = 1'b1;
         end else if (sel <= 5) begin
            det = 1'b0;
            len = int'($urandom_range(1, 7));
         end else if (sel == 6) begin
            rw  = 4'b1000;
            cs  = 4'b0110;
            det = 1'b1;
         end else if (sel == 7) begin
            det = 1'b1;
            len = int'($urandom_range(1, 3));
         end else if (sel == 8) begin
            hold(1, 1, det, rw, cs);
            continue;
         end else begin
            det = 1'b1;
            len = int'($urandom_range(20, 45));
         end
         hold(len, 0, det, rw, cs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
